// File: rtl/base_acredit_snk_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : base_acredit_snk_mc_if
// Purpose  : Bundles the credit-link input side and the ready/valid output
//            side of the multi-channel credit sink.
// Revision : 1.0 - initial release
// ============================================================================
interface base_acredit_snk_mc_if #(
    parameter int CHANNELS     = 4,
    parameter int LOG_CHANNELS = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1,
    parameter int WIDTH        = 32
);
    // Credit-link side
    logic                     i_v;
    logic [0:LOG_CHANNELS-1]  i_ch;
    logic [0:WIDTH-1]         i_d;
    logic [0:CHANNELS-1]      i_c;
    // Output stream side and status
    logic                     o_r;
    logic                     o_v;
    logic [0:LOG_CHANNELS-1]  o_ch;
    logic [0:WIDTH-1]         o_d;
    logic [0:CHANNELS-1]      o_err;
    logic                     o_bad_ch;

    // Sender / consumer view
    modport master (
        output i_v, i_ch, i_d, o_r,
        input  i_c, o_v, o_ch, o_d, o_err, o_bad_ch
    );

    // Sink view
    modport slave (
        input  i_v, i_ch, i_d, o_r,
        output i_c, o_v, o_ch, o_d, o_err, o_bad_ch
    );
endinterface
`default_nettype wire

// File: rtl/base_acredit_snk_mc.sv
`default_nettype none
// ============================================================================
// Module   : base_acredit_snk_mc
// Purpose  : Multi-channel credit sink. Per-channel FIFOs fed by one tagged
//            stream, merged through a round-robin arbiter into a registered
//            ready/valid output; one credit returned per popped entry.
// Revision : 1.0 - initial release
// ============================================================================
module base_acredit_snk_mc #(
    parameter int CHANNELS     = 4,
    parameter int LOG_CHANNELS = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1,
    parameter int CREDITS      = 8,
    parameter int LOG_CREDITS  = ($clog2(CREDITS) > 1) ? $clog2(CREDITS) : 1,
    parameter int WIDTH        = 32
) (
    input wire                   clk,
    input wire                   reset,
    base_acredit_snk_mc_if.slave bus
);

    localparam int CNT_W = LOG_CREDITS + 1;

    typedef logic [LOG_CREDITS-1:0] ptr_t;
    typedef logic [CNT_W-1:0]       cnt_t;

    // Storage is never reset; only pointers and counts define validity.
    logic [WIDTH-1:0]        mem [CHANNELS][CREDITS];
    ptr_t                    wr_ptr [CHANNELS];
    ptr_t                    rd_ptr [CHANNELS];
    cnt_t                    count  [CHANNELS];

    logic [0:CHANNELS-1]     hit;
    logic [0:CHANNELS-1]     ovf;
    logic [0:CHANNELS-1]     wr_en;
    logic [0:CHANNELS-1]     nonempty;
    logic [0:CHANNELS-1]     pop;
    logic [LOG_CHANNELS-1:0] rr_ptr;
    logic [LOG_CHANNELS-1:0] grant;
    logic                    any_req;
    logic                    load;
    logic                    bad_ch;
    int                      idx;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(CREDITS - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Per-channel write decode; a full channel drops the beat even if it pops
    // in the same cycle, because fullness is judged on the start-of-cycle count.
    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        assign hit[n]      = bus.i_v && (bus.i_ch == LOG_CHANNELS'(n));
        assign ovf[n]      = hit[n] && (count[n] == cnt_t'(CREDITS));
        assign wr_en[n]    = hit[n] && !ovf[n];
        assign nonempty[n] = (count[n] != '0);
        assign pop[n]      = load && (grant == LOG_CHANNELS'(n));
    end

    // Out-of-range tags only exist when CHANNELS is not a power of two.
    if (CHANNELS == (1 << LOG_CHANNELS)) begin : g_bad_none
        assign bad_ch = 1'b0;
    end else begin : g_bad_chk
        assign bad_ch = bus.i_v && (int'(bus.i_ch) >= CHANNELS);
    end

    // Round-robin: first nonempty channel searching upward from rr_ptr+1.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = (int'(rr_ptr) + k) % CHANNELS;
            if (!any_req && nonempty[idx]) begin
                any_req = 1'b1;
                grant   = LOG_CHANNELS'(idx);
            end
        end
    end

    assign load = (!bus.o_v || bus.o_r) && any_req;

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        for (int n = 0; n < CHANNELS; n++) begin
            if (wr_en[n]) begin
                mem[n][wr_ptr[n]] <= bus.i_d;
            end
        end
    end

    // FIFO pointers and occupancy counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < CHANNELS; n++) begin
                wr_ptr[n] <= '0;
                rd_ptr[n] <= '0;
                count[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (wr_en[n]) begin
                    wr_ptr[n] <= ptr_inc(wr_ptr[n]);
                end
                if (pop[n]) begin
                    rd_ptr[n] <= ptr_inc(rd_ptr[n]);
                end
                count[n] <= count[n] + cnt_t'(wr_en[n]) - cnt_t'(pop[n]);
            end
        end
    end

    // Output register, arbiter pointer, credit return and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.o_v      <= 1'b0;
            bus.o_ch     <= '0;
            bus.o_d      <= '0;
            bus.i_c      <= '0;
            bus.o_err    <= '0;
            bus.o_bad_ch <= 1'b0;
            rr_ptr       <= LOG_CHANNELS'(CHANNELS - 1);
        end else begin
            if (load) begin
                bus.o_v  <= 1'b1;
                bus.o_ch <= grant;
                bus.o_d  <= mem[grant][rd_ptr[grant]];
                rr_ptr   <= grant;
            end else if (bus.o_r) begin
                bus.o_v  <= 1'b0;
            end
            bus.i_c      <= pop;
            bus.o_err    <= bus.o_err | ovf;
            bus.o_bad_ch <= bus.o_bad_ch | bad_ch;
        end
    end

endmodule
`default_nettype wire
